// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the CPU/DMA memory port arbiter
package mem_arb_pkg;
  localparam int XLEN_P   = 32;
  localparam int ADDR_W_P = 32;
  typedef enum logic {ARB_CPU_PRI, ARB_DMA_FORCE} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} rd_owner_t;
  typedef struct packed {
    logic                we;
    logic [ADDR_W_P-1:0] addr;
    logic [XLEN_P-1:0]   wdata;
    logic [3:0]          wstrb;
  } mem_req_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: DMA wait counter, starvation limit compare and saturating forced-grant counter
//   i_dma_req/i_dma_gnt : DMA request and grant this cycle
//   i_force_gnt         : a grant issued while the arbiter is forcing DMA
//   o_limit_hit         : wait count reaches the limit at this edge
//   o_starve_events     : saturating count of forced grants
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_dma_req,
  input  logic        i_dma_gnt,
  input  logic        i_force_gnt,
  output logic        o_limit_hit,
  output logic [15:0] o_starve_events
);
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_nxt;
  logic [15:0] r_starve;
  always_comb w_wait_nxt = (!i_dma_req || i_dma_gnt) ? 4'd0 :
                           (r_wait_cnt == 4'hF) ? r_wait_cnt : r_wait_cnt + 4'd1;
  // Compare the post-edge count so the forced grant lands right after the limit-th loss
  assign o_limit_hit     = w_wait_nxt == 4'(STARVE_LIMIT);
  assign o_starve_events = r_starve;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_starve   <= '0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      if (i_force_gnt && r_starve != 16'hFFFF) r_starve <= r_starve + 16'd1;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: CPU-priority arbiter for a single-ported RAM with bounded DMA starvation
//   cpu_*/dma_* : request/payload in, grant and routed read response out
//   mem_*       : winner's access to the RAM, mem_rdata returns one cycle after a read
//   starve_events : saturating count of forced DMA grants
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [XLEN-1:0]   cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [XLEN-1:0]   cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [XLEN-1:0]   dma_wdata,
  input  logic [3:0]        dma_wstrb,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [XLEN-1:0]   dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [15:0]       starve_events
);
  arb_state_t r_state, w_state_nxt;
  rd_owner_t  r_rd_owner;
  mem_req_t   w_cpu, w_dma, w_win;
  logic       w_force, w_limit_hit;
  assign w_cpu = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, wstrb: cpu_wstrb};
  assign w_dma = '{we: dma_we, addr: dma_addr, wdata: dma_wdata, wstrb: dma_wstrb};
  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_CPU_PRI;
    else r_state <= w_state_nxt;
  end
  // The forced state always lasts one cycle, whether or not DMA still requests
  always_comb w_state_nxt = (r_state == ARB_CPU_PRI && w_limit_hit) ? ARB_DMA_FORCE : ARB_CPU_PRI;
  always_comb begin
    w_force = r_state == ARB_DMA_FORCE;
    dma_gnt = dma_req && (w_force || !cpu_req);
    cpu_gnt = cpu_req && !dma_gnt;
  end
  assign w_win     = cpu_gnt ? w_cpu : dma_gnt ? w_dma : '0;
  assign mem_en    = cpu_gnt | dma_gnt;
  assign mem_we    = w_win.we;
  assign mem_addr  = {w_win.addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = w_win.wdata;
  assign mem_wstrb = w_win.wstrb;
  always_ff @(posedge clk) begin
    if (rst) r_rd_owner <= OWN_NONE;
    else r_rd_owner <= (mem_en && !mem_we) ? (cpu_gnt ? OWN_CPU : OWN_DMA) : OWN_NONE;
  end
  assign cpu_rvalid = r_rd_owner == OWN_CPU;
  assign dma_rvalid = r_rd_owner == OWN_DMA;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;
  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk             (clk),
    .rst             (rst),
    .i_dma_req       (dma_req),
    .i_dma_gnt       (dma_gnt),
    .i_force_gnt     (w_force && dma_gnt),
    .o_limit_hit     (w_limit_hit),
    .o_starve_events (starve_events)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a rule-level model
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  logic        clk = 0, rst = 1;
  logic        cpu_req = 0, cpu_we = 0, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic [3:0]  cpu_wstrb = 0;
  logic        dma_req = 0, dma_we = 0, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr = 0, dma_wdata = 0, dma_rdata;
  logic [3:0]  dma_wstrb = 0;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [15:0] starve_events;
  int tests = 0, fails = 0;
  logic [31:0] ram [1024];
  logic [31:0] ref_mem [1024];
  int          losses = 0, own_exp = 0;
  logic [15:0] starve_exp = 0;
  logic [31:0] rdata_exp = 0;
  logic        last_cg, last_dg, last_dg_obs;
  mem_port_arbiter #(.XLEN(32), .ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_wstrb(dma_wstrb), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .starve_events(starve_events)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++) if (mem_wstrb[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[11:2]];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  // One bus cycle: drive, check mid-cycle against the model, advance the model, cross the edge
  task automatic cyc(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic [3:0] cs, input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] dd, input logic [3:0] ds);
    logic force_now, eg_c, eg_d, g, w_we;
    logic [31:0] w_a, w_d;
    logic [3:0]  w_s;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; cpu_wstrb = cs;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_wstrb = ds;
    @(negedge clk);
    force_now = losses == LIMIT;
    eg_d = dr && (!cr || force_now);
    eg_c = cr && !eg_d;
    g    = eg_c || eg_d;
    w_we = g && (eg_c ? cw : dw);
    w_a  = !g ? 32'h0 : (eg_c ? ca : da) & ~32'h3;
    w_d  = !g ? 32'h0 : eg_c ? cd : dd;
    w_s  = !g ? 4'h0 : eg_c ? cs : ds;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
    chk("dma_gnt", 32'(dma_gnt), 32'(eg_d));
    chk("mem_en", 32'(mem_en), 32'(g));
    chk("mem_we", 32'(mem_we), 32'(w_we));
    chk("mem_addr", mem_addr, w_a);
    chk("mem_wdata", mem_wdata, w_d);
    chk("mem_wstrb", 32'(mem_wstrb), 32'(w_s));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(own_exp == 1));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(own_exp == 2));
    chk("cpu_rdata", cpu_rdata, own_exp == 1 ? rdata_exp : 32'h0);
    chk("dma_rdata", dma_rdata, own_exp == 2 ? rdata_exp : 32'h0);
    chk("starve_events", 32'(starve_events), 32'(starve_exp));
    last_cg = eg_c; last_dg = eg_d; last_dg_obs = dma_gnt;
    rdata_exp = ref_mem[w_a[11:2]];
    if (w_we) for (int b = 0; b < 4; b++) if (w_s[b]) ref_mem[w_a[11:2]][8*b +: 8] = w_d[8*b +: 8];
    own_exp = (rst || !g || w_we) ? 0 : (eg_c ? 1 : 2);
    if (force_now && eg_d && starve_exp != 16'hFFFF) starve_exp++;
    losses = (dr && !eg_d) ? losses + 1 : 0;
    if (rst) begin starve_exp = 0; losses = 0; end
    @(posedge clk); #1;
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    logic [31:0] src_v [16];
    logic [31:0] cval, dval;
    int cph, dph, di, incs;
    for (int i = 0; i < 1024; i++) begin ram[i] = $urandom; ref_mem[i] = ram[i]; end
    ram[10'h080] = 32'hA0000000; ref_mem[10'h080] = 32'hA0000000;
    repeat (2) @(posedge clk);
    #1;
    idle();
    rst = 0;
    idle();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 32'h200, 0, 0, 0, 0, 0, 0, 0);
      chk("cpu_only_rdata", cpu_rdata, 32'hA0000000);
      chk("cpu_only_dma_rvalid", 32'(dma_rvalid), 0);
    end
    idle();
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, 1, 1, 32'h300 + 32'(4*i), 32'hA0000000 + 32'(i), 4'hF);
    for (int i = 0; i < 16; i++) chk("dma_only_mem", ram[10'h0C0 + 10'(i)], 32'hA0000000 + 32'(i));
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 32'h100, 0, 0, 1, 0, 32'h104, 0, 0);
      chk("contend_pattern", 32'(last_dg_obs), 32'(i % 5 == 4));
    end
    chk("contend_starve", 32'(starve_events), 4);
    ram[10'h140] = 32'h11111111; ref_mem[10'h140] = 32'h11111111;
    ram[10'h081] = 32'h22222222; ref_mem[10'h081] = 32'h22222222;
    ram[10'h141] = 32'h33333333; ref_mem[10'h141] = 32'h33333333;
    cyc(1, 0, 32'h500, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 32'h204, 0, 0);
    chk("alt_cpu_data", cpu_rdata, 32'h0);
    chk("alt_dma_data", dma_rdata, 32'h22222222);
    cyc(1, 0, 32'h504, 0, 0, 0, 0, 0, 0, 0);
    idle();
    rst = 1;
    cyc(0, 0, 0, 0, 0, 1, 0, 32'h208, 0, 0);
    rst = 0;
    chk("rst_dma_rvalid", 32'(dma_rvalid), 0);
    idle();
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 4095)), $urandom,
          4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, 4095)), $urandom, 4'($urandom));
    idle();
    for (int i = 0; i < 16; i++) begin
      src_v[i] = $urandom; ram[10'h080 + 10'(i)] = src_v[i]; ref_mem[10'h080 + 10'(i)] = src_v[i];
    end
    ram[10'h140] = 0; ref_mem[10'h140] = 0;
    cph = 0; dph = 0; di = 0; incs = 0; cval = 0; dval = 0;
    for (int n = 0; n < 5000 && di < 16; n++) begin
      cyc(cph != 1, cph == 2, 32'h500, cval, 4'hF, dph != 1, dph == 2,
          (dph == 2 ? 32'h300 : 32'h200) + 32'(4*di), dval, 4'hF);
      if (cph == 2 && last_cg) begin cph = 0; incs++; end
      else if (cph == 0 && last_cg) cph = 1;
      if (cph == 1 && cpu_rvalid) begin cval = cpu_rdata + 1; cph = 2; end
      if (dph == 2 && last_dg) begin dph = 0; di++; end
      else if (dph == 0 && last_dg) dph = 1;
      if (dph == 1 && dma_rvalid) begin dval = dma_rdata; dph = 2; end
    end
    chk("fs_dma_done", 32'(di), 16);
    chk("fs_cpu_progress", 32'(incs > 0), 1);
    chk("fs_counter", ram[10'h140], 32'(incs));
    for (int i = 0; i < 16; i++) chk("fs_copy", ram[10'h0C0 + 10'(i)], src_v[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported unified RAM between the CPU load/store/fetch port and the DMA engine's master port, so DMA copies proceed while both harts keep executing. Sits in `soc_top` between `u_cpu`/`u_dma` and `u_mem`. Uses a fixed CPU-priority policy with a bounded DMA starvation guarantee. Routes each read response back to the master that issued the request.

## Interface
- `XLEN`, 32: data width.
- `ADDR_W`, 32: address width.
- `STARVE_LIMIT`, 4: maximum consecutive cycles a requesting DMA may lose arbitration; range 1..15.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cpu_req` input 1: CPU access request; held with its payload until `cpu_gnt`.
- `cpu_we` input 1: 1 = write, 0 = read.
- `cpu_addr` input ADDR_W: byte address; bits [1:0] ignored.
- `cpu_wdata` input XLEN: write data.
- `cpu_wstrb` input 4: byte write enables.
- `cpu_gnt` output 1: request accepted this cycle.
- `cpu_rvalid` output 1: read data valid.
- `cpu_rdata` output XLEN: read data.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_wstrb`, `dma_gnt`, `dma_rvalid`, `dma_rdata`: identical to the CPU set, for the DMA port.
- `mem_en` output 1: RAM access this cycle.
- `mem_we` output 1: RAM write.
- `mem_addr` output ADDR_W: word-aligned RAM address.
- `mem_wdata` output XLEN: RAM write data.
- `mem_wstrb` output 4: RAM byte enables.
- `mem_rdata` input XLEN: RAM read data, valid one cycle after `mem_en && !mem_we`.
- `starve_events` output 16: saturating count of forced DMA grants (debug).

## Operation
- A transfer occurs in any cycle where `X_req && X_gnt`. At most one grant is asserted per cycle. `mem_*` is driven from the winner's payload; `mem_en = cpu_gnt | dma_gnt`.
- The FSM has two states:
  - `ARB_CPU_PRI` (reset state): CPU wins whenever `cpu_req=1`. DMA wins only when `cpu_req=0`.
  - `ARB_DMA_FORCE`: DMA wins unconditionally for exactly one grant, then the FSM returns to `ARB_CPU_PRI`.
- `wait_cnt` is a 4-bit counter:
  - Increments each cycle with `dma_req && !dma_gnt`.
  - Clears on any `dma_gnt`, or when `dma_req=0`.
  - When it reaches `STARVE_LIMIT`, the next state is `ARB_DMA_FORCE`.
  - If `dma_req` drops while in `ARB_DMA_FORCE`, the FSM returns to `ARB_CPU_PRI` with no grant issued.
- Response routing:
  - `rd_owner` (enum NONE/CPU/DMA) is registered from the winner when the winning access is a read.
  - Next cycle, `X_rvalid=1` for the owner only, and `X_rdata = mem_rdata`.
  - The non-owner's `X_rdata` is held at 0.
- Writes produce no response.
- Back-to-back reads from alternating masters must route correctly every cycle.
- `starve_events` increments on each grant issued in `ARB_DMA_FORCE` and saturates at 0xFFFF.

## Timing
- Grant is combinational from `req`, the FSM state and `wait_cnt`, with zero cycles of latency. There is no combinational path from `mem_rdata` to any grant.
- Read latency is 1 cycle from grant to `rvalid`. Throughput is one access per cycle.
- Reset values:
  - `cpu_gnt`, `dma_gnt`, `cpu_rvalid`, `dma_rvalid`, `mem_en`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `mem_wstrb`, `cpu_rdata`, `dma_rdata` = 0.
  - `starve_events` = 0, state = `ARB_CPU_PRI`, `wait_cnt` = 0, `rd_owner` = NONE.
- Reset asserted mid-operation: a read granted in the reset cycle produces no `rvalid`, and all state clears on that edge.
- Simultaneous requests in `ARB_CPU_PRI` with `wait_cnt < STARVE_LIMIT`: CPU wins.
- Simultaneous requests in `ARB_DMA_FORCE`: DMA wins, and `cpu_gnt=0` that cycle.
- Requests with no competitor are granted the same cycle in either state.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the `arb_state_t` enum (`ARB_CPU_PRI`, `ARB_DMA_FORCE`);
  - the `rd_owner_t` enum (`OWN_NONE`, `OWN_CPU`, `OWN_DMA`);
  - the `mem_req_t` struct (we, addr, wdata, wstrb).
- `XLEN`, `ADDR_W` and `MEM_SIZE_BYTES` remain in `defines.vh`.
- One sub-module, `arb_starve_ctr`: wait counter, limit compare and the saturating `starve_events` counter. Everything else stays flat.

## Test plan
- CPU only: CPU reads `0x200` for 4 consecutive cycles. Required response: `cpu_gnt=1` every cycle, `cpu_rvalid` one cycle later each time, `cpu_rdata=0xA0000000..`, `dma_rvalid=0` throughout.
- DMA only: DMA writes `0x300..0x33C` (16 words). Required response: 16 grants in 16 cycles, and `mem[0x300>>2+i] = 0xA0000000+i`.
- Contention, `STARVE_LIMIT=4`: `cpu_req` and `dma_req` held high for 20 cycles. Required response: grant pattern CPU×4, DMA×1 repeating; `starve_events=4` at the end.
- Alternating reads (CPU `0x500`, DMA `0x204`, CPU `0x504`) on consecutive cycles. Required response: each `rdata` goes to the correct master with exactly one `rvalid` per cycle.
- Reset on the cycle a DMA read is granted. Required response: `dma_rvalid` stays 0 next cycle, and all outputs are 0.
- Full system: the CPU increments the counter at `0x500` while DMA copies 64 bytes `0x200→0x300`. Required response: the counter advances during the DMA busy period, and the destination matches within 5000 cycles.
